// File: rtl/pyramid_uart_dumper.sv
// Streams every Gaussian-pyramid image (octave-major, level-minor, raster order) to a UART byte sink.
// Define PYRAMID_DUMP_HEADER_EN to prefix each image with a {4'hA, octave, level} header byte.
module pyramid_uart_dumper #(
    parameter int TOP_WIDTH    = 64,
    parameter int TOP_HEIGHT   = 64,
    parameter int BIT_DEPTH    = 8,
    parameter int NUM_OCTAVES  = 3,
    parameter int NUM_LEVELS   = 3,
    parameter int BRAM_LATENCY = 2,
    localparam int OCT_W  = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1,
    localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int ADDR_W = $clog2(TOP_WIDTH * TOP_HEIGHT)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [OCT_W-1:0]     sel_octave_out,
    output logic [LVL_W-1:0]     sel_level_out,
    output logic [ADDR_W-1:0]    read_addr_out,
    output logic                 read_en_out,
    input  logic [BIT_DEPTH-1:0] pixel_in,
    output logic [BIT_DEPTH-1:0] tx_data_out,
    output logic                 tx_valid_out,
    input  logic                 tx_ready_in,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam logic [ADDR_W:0] TOP_PIX = (ADDR_W + 1)'(TOP_WIDTH * TOP_HEIGHT);
    localparam int LAT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;

`ifdef PYRAMID_DUMP_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_WAIT, S_SEND} state_t;

    function automatic logic [BIT_DEPTH-1:0] header_byte(input logic [OCT_W-1:0] oct,
                                                         input logic [LVL_W-1:0] lvl);
        logic [7:0] hdr;
        hdr = {4'hA, 2'(oct), 2'(lvl)};
        return BIT_DEPTH'(hdr);
    endfunction
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND} state_t;
`endif

    state_t            state;
    logic [LAT_W-1:0]  wait_cnt;
    logic [ADDR_W:0]   img_pix;
    logic              last_addr;
    logic              last_level;
    logic              last_octave;
    logic [OCT_W-1:0]  next_oct;
    logic [LVL_W-1:0]  next_lvl;

    // Each octave halves both dimensions, so the pixel count drops by 4x per octave.
    always_comb begin
        img_pix     = TOP_PIX >> {sel_octave_out, 1'b0};
        last_addr   = ({1'b0, read_addr_out} == img_pix - (ADDR_W + 1)'(1));
        last_level  = (sel_level_out == LVL_W'(NUM_LEVELS - 1));
        last_octave = (sel_octave_out == OCT_W'(NUM_OCTAVES - 1));
        next_lvl    = last_level ? '0 : sel_level_out + LVL_W'(1);
        next_oct    = last_level ? sel_octave_out + OCT_W'(1) : sel_octave_out;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= S_IDLE;
            sel_octave_out <= '0;
            sel_level_out  <= '0;
            read_addr_out  <= '0;
            read_en_out    <= 1'b0;
            tx_data_out    <= '0;
            tx_valid_out   <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            read_en_out <= 1'b0;
            done_out    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        busy_out       <= 1'b1;
                        sel_octave_out <= '0;
                        sel_level_out  <= '0;
                        read_addr_out  <= '0;
`ifdef PYRAMID_DUMP_HEADER_EN
                        tx_data_out    <= header_byte('0, '0);
                        tx_valid_out   <= 1'b1;
                        state          <= S_HDR;
`else
                        read_en_out    <= 1'b1;
                        state          <= S_FETCH;
`endif
                    end
                end
`ifdef PYRAMID_DUMP_HEADER_EN
                S_HDR: begin
                    if (tx_ready_in) begin
                        tx_valid_out <= 1'b0;
                        read_en_out  <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
`endif
                S_FETCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == LAT_W'(BRAM_LATENCY - 1)) begin
                        tx_data_out  <= pixel_in;
                        tx_valid_out <= 1'b1;
                        state        <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + LAT_W'(1);
                    end
                end
                S_SEND: begin
                    if (tx_ready_in) begin
                        tx_valid_out <= 1'b0;
                        if (!last_addr) begin
                            read_addr_out <= read_addr_out + ADDR_W'(1);
                            read_en_out   <= 1'b1;
                            state         <= S_FETCH;
                        end else if (last_level && last_octave) begin
                            done_out       <= 1'b1;
                            busy_out       <= 1'b0;
                            sel_octave_out <= '0;
                            sel_level_out  <= '0;
                            read_addr_out  <= '0;
                            state          <= S_IDLE;
                        end else begin
                            sel_octave_out <= next_oct;
                            sel_level_out  <= next_lvl;
                            read_addr_out  <= '0;
`ifdef PYRAMID_DUMP_HEADER_EN
                            tx_data_out    <= header_byte(next_oct, next_lvl);
                            tx_valid_out   <= 1'b1;
                            state          <= S_HDR;
`else
                            read_en_out    <= 1'b1;
                            state          <= S_FETCH;
`endif
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
